// File: rtl/flag_intersex_anim.sv
`default_nettype none
// ============================================================================
//  Module      : flag_intersex_anim
//  Description : Animated intersex flag generator. Draws a yellow 50 %
//                dithered field with a purple ring centred at (CX, CY).
//                The ring radius is either static or pulsed once per frame.
//                Squares of the radius are kept incrementally, so there is
//                no radius multiplier.
//  Ports       : clk    - pixel clock
//                rst_n  - asynchronous active-low reset
//                pix_x  - current pixel x (10 bits)
//                pix_y  - current pixel y (10 bits)
//                frame  - one-cycle pulse at the start of each frame
//                mode   - 0 static, 1 triangle pulse, 2 pulse with dwell,
//                         3 ring off
//                color  - registered RRGGBB colour, 2-cycle pixel latency
//  Revision    : 1.0 - initial release
// ============================================================================
module flag_intersex_anim #(
  parameter int unsigned CX         = 320,
  parameter int unsigned CY         = 240,
  parameter int unsigned R_INIT     = 100,
  parameter int unsigned THICK      = 41,
  parameter int unsigned R_MIN      = 80,
  parameter int unsigned R_MAX      = 120,
  parameter int unsigned STEP_DIV   = 2,
  parameter int unsigned HOLD       = 30,
  parameter logic [5:0]  RING_COLOR = 6'b100011
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       frame,
  input  logic [1:0] mode,
  output logic [5:0] color
);

  localparam logic [9:0]  CX_V      = 10'(CX);
  localparam logic [9:0]  CY_V      = 10'(CY);
  localparam logic [7:0]  R_INIT_V  = 8'(R_INIT);
  localparam logic [15:0] IN2_INIT  = 16'(R_INIT * R_INIT);
  localparam logic [16:0] OUT2_INIT = 17'((R_INIT + THICK) * (R_INIT + THICK));
  localparam logic [8:0]  THICK_V   = 9'(THICK);
  localparam logic [7:0]  R_TOP     = 8'(R_MAX - 1);  // r value whose increment reaches R_MAX
  localparam logic [7:0]  R_BOT     = 8'(R_MIN + 1);  // r value whose decrement reaches R_MIN
  localparam logic [3:0]  STEP_LAST = 4'(STEP_DIV - 1);
  localparam logic [7:0]  HOLD_LAST = (HOLD == 0) ? 8'd0 : 8'(HOLD - 1);

  localparam logic [5:0]  DITHER_0  = 6'b111100;
  localparam logic [5:0]  DITHER_1  = 6'b111000;

  localparam logic [1:0]  ST_GROW    = 2'd0;
  localparam logic [1:0]  ST_HOLD_HI = 2'd1;
  localparam logic [1:0]  ST_SHRINK  = 2'd2;
  localparam logic [1:0]  ST_HOLD_LO = 2'd3;

  // --------------------------------------------------------------------------
  // Pixel pipeline
  // --------------------------------------------------------------------------
  logic [9:0]  ax, ay;
  logic        in_box, phase;
  logic [9:0]  ax_nxt, ay_nxt;
  logic [16:0] d2;
  logic        ring;

  logic [7:0]  r;
  logic [15:0] in2;
  logic [16:0] out2;

  assign ax_nxt = (pix_x >= CX_V) ? (pix_x - CX_V) : (CX_V - pix_x);
  assign ay_nxt = (pix_y >= CY_V) ? (pix_y - CY_V) : (CY_V - pix_y);

  assign d2   = 17'(ax[7:0]) * 17'(ax[7:0]) + 17'(ay[7:0]) * 17'(ay[7:0]);
  // mode is taken live here so that "ring off" acts per pixel.
  assign ring = in_box && ({1'b0, in2} <= d2) && (d2 < out2) && (mode != 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ax     <= '0;
      ay     <= '0;
      in_box <= 1'b0;
      phase  <= 1'b0;
      color  <= '0;
    end else begin
      ax     <= ax_nxt;
      ay     <= ay_nxt;
      in_box <= (ax_nxt[9:8] == 2'b00) && (ay_nxt[9:8] == 2'b00);
      phase  <= pix_x[0] ^ pix_y[0];
      color  <= ring ? RING_COLOR : (phase ? DITHER_1 : DITHER_0);
    end
  end

  // --------------------------------------------------------------------------
  // Radius animation FSM
  // --------------------------------------------------------------------------
  logic [1:0] state, state_nxt;
  logic [3:0] div;
  logic [7:0] hold;
  logic       anim_mode, animate, step, hold_done;
  logic       grow_en, shrink_en, load, hold_inc, hold_clr;
  logic [8:0] rt;

  assign anim_mode = (mode == 2'd1) || (mode == 2'd2);
  assign animate   = frame && anim_mode;
  assign step      = (div == STEP_LAST);
  // Switching to mode 1 during a dwell releases it on the next frame.
  assign hold_done = (HOLD == 0) || (hold == HOLD_LAST) || (mode == 2'd1);
  assign rt        = {1'b0, r} + THICK_V;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_GROW;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame) begin
      if (!anim_mode) begin
        state_nxt = ST_GROW;
      end else begin
        case (state)
          ST_GROW:    if (step && (r == R_TOP))
                        state_nxt = (mode == 2'd2) ? ST_HOLD_HI : ST_SHRINK;
          ST_SHRINK:  if (step && (r == R_BOT))
                        state_nxt = (mode == 2'd2) ? ST_HOLD_LO : ST_GROW;
          ST_HOLD_HI: if (hold_done) state_nxt = ST_SHRINK;
          ST_HOLD_LO: if (hold_done) state_nxt = ST_GROW;
          default:    state_nxt = ST_GROW;
        endcase
      end
    end
  end

  always_comb begin
    load      = frame && !anim_mode;
    grow_en   = animate && step && (state == ST_GROW);
    shrink_en = animate && step && (state == ST_SHRINK);
    hold_inc  = animate && ((state == ST_HOLD_HI) || (state == ST_HOLD_LO));
    hold_clr  = load || (hold_inc && hold_done);
  end

  // Squares track r incrementally: (r+-1)^2 = r^2 +- (2r +- 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r    <= R_INIT_V;
      in2  <= IN2_INIT;
      out2 <= OUT2_INIT;
      div  <= '0;
      hold <= '0;
    end else begin
      if (load) begin
        r    <= R_INIT_V;
        in2  <= IN2_INIT;
        out2 <= OUT2_INIT;
        div  <= '0;
      end else if (animate) begin
        div <= step ? 4'd0 : div + 4'd1;
        if (grow_en) begin
          r    <= r + 8'd1;
          in2  <= in2 + {7'b0, r, 1'b1};
          out2 <= out2 + {7'b0, rt, 1'b1};
        end else if (shrink_en) begin
          r    <= r - 8'd1;
          in2  <= in2 - ({7'b0, r, 1'b0} - 16'd1);
          out2 <= out2 - ({7'b0, rt, 1'b0} - 17'd1);
        end
      end
      if (hold_clr)      hold <= '0;
      else if (hold_inc) hold <= hold + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flag_intersex_anim.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flag_intersex_anim
//  Description : Self-checking bench for flag_intersex_anim. A behavioural
//                model tracks the radius as a plain integer with a direction
//                and a dwell counter, and predicts every pixel colour from
//                the circle equation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_intersex_anim;

  localparam int CX = 320, CY = 240, R_INIT = 100, THICK = 41;
  localparam int R_MIN = 80, R_MAX = 120, STEP_DIV = 2, HOLD = 30;
  localparam logic [5:0] RING_COLOR = 6'b100011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic       frame;
  logic [1:0] mode;
  logic [5:0] color;

  flag_intersex_anim #(
    .CX(CX), .CY(CY), .R_INIT(R_INIT), .THICK(THICK), .R_MIN(R_MIN),
    .R_MAX(R_MAX), .STEP_DIV(STEP_DIV), .HOLD(HOLD), .RING_COLOR(RING_COLOR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .frame(frame), .mode(mode), .color(color)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state
  int m_r, m_dir, m_dwell, m_dcnt, m_div;
  int prev_px, prev_py;
  bit prev_valid;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (r=%0d)", tag, got, exp, m_r);
    end
  endtask

  function automatic logic [5:0] color_of(input int px, input int py, input int rad,
                                          input logic [1:0] md);
    int dx, dy, d2;
    bit inbox;
    dx = px - CX; if (dx < 0) dx = -dx;
    dy = py - CY; if (dy < 0) dy = -dy;
    inbox = (dx < 256) && (dy < 256);
    d2 = dx * dx + dy * dy;
    if (inbox && d2 >= rad * rad && d2 < (rad + THICK) * (rad + THICK) && md != 2'd3)
      return RING_COLOR;
    return ((px ^ py) & 1) != 0 ? 6'b111000 : 6'b111100;
  endfunction

  task automatic model_reset();
    m_r = R_INIT; m_dir = 1; m_dwell = 0; m_dcnt = 0; m_div = 0;
  endtask

  task automatic model_frame(input logic [1:0] md);
    bit step;
    if (md == 2'd0 || md == 2'd3) begin
      model_reset();
    end else begin
      step  = (m_div == STEP_DIV - 1);
      m_div = step ? 0 : m_div + 1;
      if (m_dwell != 0) begin
        m_dcnt++;
        if (md == 2'd1 || m_dcnt >= HOLD) begin
          m_dwell = 0; m_dcnt = 0;
        end
      end else if (step) begin
        m_r += m_dir;
        if (m_dir > 0 && m_r == R_MAX) begin
          m_dir = -1; m_dwell = (md == 2'd2);
        end else if (m_dir < 0 && m_r == R_MIN) begin
          m_dir = 1; m_dwell = (md == 2'd2);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock: the colour seen after this edge belongs to the pixel driven
  // one call earlier, judged against the radius before this edge's frame.
  task automatic cycle(input int px, input int py, input bit frm,
                       input logic [1:0] md, input string tag);
    logic [5:0] exp;
    pix_x = 10'(px); pix_y = 10'(py); frame = frm; mode = md;
    exp = color_of(prev_px, prev_py, m_r, md);
    tick();
    if (prev_valid) check(tag, color, exp);
    if (frm) model_frame(md);
    prev_px = px; prev_py = py; prev_valid = 1'b1;
  endtask

  task automatic probe(input logic [1:0] md);
    cycle(CX + m_r - 1,     CY, 1'b0, md, "inner_out");
    cycle(CX + m_r,         CY, 1'b0, md, "inner_edge");
    cycle(CX + m_r + THICK - 1, CY, 1'b0, md, "outer_edge");
    cycle(CX + m_r + THICK, CY, 1'b0, md, "outer_out");
    cycle(CX - m_r,         CY, 1'b0, md, "left_edge");
  endtask

  task automatic pulse(input logic [1:0] md);
    cycle($urandom_range(639), $urandom_range(479), 1'b1, md, "pulse_pix");
  endtask

  initial begin
    logic [1:0] md;
    int guard;
    rst_n = 1'b0; pix_x = '0; pix_y = '0; frame = 1'b0; mode = 2'd0;
    model_reset();
    prev_valid = 1'b0; prev_px = 0; prev_py = 0;
    repeat (3) tick();
    check("rst_color", color, 6'b000000);
    rst_n = 1'b1;

    // static ring, directed pixels
    cycle(420, 240, 1'b0, 2'd0, "warm");
    cycle(320, 240, 1'b0, 2'd0, "ring_420");
    cycle(321, 240, 1'b0, 2'd0, "centre_even");
    cycle(461, 240, 1'b0, 2'd0, "centre_odd");
    cycle(461, 240, 1'b0, 2'd0, "outer_excl");
    check("const_ring", color_of(420, 240, R_INIT, 2'd0), RING_COLOR);
    pulse(2'd0);
    probe(2'd0);

    // triangle pulse: up to R_MAX, then down to R_MIN
    for (int i = 0; i < 120; i++) begin
      pulse(2'd1);
      probe(2'd1);
    end

    // randomized mix of pixels, frames and mode changes
    md = 2'd1;
    for (int i = 0; i < 2000; i++) begin
      int px, py;
      if ($urandom_range(63) == 0) md = 2'($urandom_range(3));
      if ($urandom_range(1) == 0) begin
        px = $urandom_range(1023); py = $urandom_range(1023);
      end else begin
        px = CX + m_r + $urandom_range(THICK + 1) - 1; py = CY + $urandom_range(2) - 1;
      end
      cycle(px, py, ($urandom_range(7) == 0), md, "rand");
    end

    // pulse with dwell from a clean start
    pulse(2'd0);
    for (int i = 0; i < 200; i++) begin
      pulse(2'd2);
      probe(2'd2);
    end

    // ring off, then back to static
    for (int i = 0; i < 20; i++)
      cycle($urandom_range(639), $urandom_range(479), 1'b0, 2'd3, "off_rand");
    cycle(420, 240, 1'b0, 2'd3, "off_a");
    cycle(420, 240, 1'b0, 2'd3, "off_420");
    cycle(420, 240, 1'b0, 2'd0, "on_a");
    cycle(420, 240, 1'b0, 2'd0, "on_420");
    pulse(2'd0);
    probe(2'd0);

    // asynchronous reset mid-animation at r = 113
    guard = 0;
    while (m_r != 113 && guard < 200) begin
      pulse(2'd1);
      guard++;
    end
    check("reach_113", (m_r == 113) ? 6'd1 : 6'd0, 6'd1);
    cycle(CX + m_r, CY, 1'b0, 2'd1, "pre_rst");
    cycle(CX + m_r, CY, 1'b0, 2'd1, "pre_rst_ring");
    #2 rst_n = 1'b0;
    #1 check("async_rst", color, 6'b000000);
    model_reset();
    prev_valid = 1'b0;
    tick();
    check("rst_hold", color, 6'b000000);
    rst_n = 1'b1;
    probe(2'd1);
    pulse(2'd1);
    pulse(2'd1);
    probe(2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
